serial_tx_fifo: RTL and testbench

SERIAL_TX_FIFO -- requirements
Module: serial_tx_fifo

---
 rtl/serial_tx_fifo.sv | 77 +++++++
 tb/tb_serial_tx_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_fifo.sv
// Byte FIFO between a CPU-side bus register and a serial transmitter.
// Define SERIAL_TX_FIFO_OVERFLOW_EN to enable the sticky overflow flag.
module serial_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int THRESHOLD_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_valid,
  input  logic [7:0]                 wr_data,
  output logic                       wr_ready,
  output logic                       rd_valid,
  output logic [7:0]                 rd_data,
  input  logic                       rd_ready,
  output logic [THRESHOLD_WIDTH-1:0] level,
  input  logic [THRESHOLD_WIDTH-1:0] threshold,
  input  logic                       irq_enable,
  output logic                       irq,
  output logic                       overflow,
  input  logic                       overflow_clear
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [THRESHOLD_WIDTH-1:0] FULL =
    THRESHOLD_WIDTH'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign wr_ready = (level != FULL);
  assign rd_valid = (level != '0);
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = mem[rd_ptr];
  assign irq      = irq_enable && (level <= threshold);

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; only valid entries are ever presented.
  always_ff @(posedge clk) begin
    if (reset && !flush && push) mem[wr_ptr] <= wr_data;
  end

`ifdef SERIAL_TX_FIFO_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (!reset)
      overflow <= 1'b0;
    else if (wr_valid && level == FULL)
      overflow <= 1'b1;
    else if (overflow_clear)
      overflow <= 1'b0;
  end
`else
  logic unused_overflow_clear;
  assign unused_overflow_clear = overflow_clear;
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Randomized + directed bench for serial_tx_fifo against a queue model.
// Honours SERIAL_TX_FIFO_OVERFLOW_EN when predicting overflow.
module tb_serial_tx_fifo;

  localparam int DEPTH = 16;
  localparam int TW = 5;

`ifdef SERIAL_TX_FIFO_OVERFLOW_EN
  localparam int OVF_ON = 1;
`else
  localparam int OVF_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          wr_valid = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          wr_ready;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic          rd_ready = 1'b0;
  logic [TW-1:0] level;
  logic [TW-1:0] threshold = '0;
  logic          irq_enable = 1'b0;
  logic          irq;
  logic          overflow;
  logic          overflow_clear = 1'b0;

  int checks = 0;
  int errors = 0;

  byte unsigned q[$];
  bit m_ovf = 1'b0;

  always #5 clk = ~clk;

  serial_tx_fifo #(.DEPTH(DEPTH), .THRESHOLD_WIDTH(TW)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .wr_valid(wr_valid),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .rd_ready(rd_ready),
    .level(level),
    .threshold(threshold),
    .irq_enable(irq_enable),
    .irq(irq),
    .overflow(overflow),
    .overflow_clear(overflow_clear)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue, updated on each rising edge.
  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    if (!reset) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (OVF_ON != 0) begin
        if (wr_valid && q.size() == DEPTH) m_ovf = 1'b1;
        else if (overflow_clear) m_ovf = 1'b0;
      end
      if (flush) begin
        q.delete();
      end else begin
        do_pop  = rd_ready && q.size() > 0;
        do_push = wr_valid && q.size() < DEPTH;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(wr_data);
      end
    end
  end

  // Monitor: compares DUT outputs with the model away from the edge.
  always @(negedge clk) begin
    chk("mon_level", int'(level), q.size());
    chk("mon_wr_ready", int'(wr_ready), int'(q.size() != DEPTH));
    chk("mon_rd_valid", int'(rd_valid), int'(q.size() != 0));
    chk("mon_irq", int'(irq),
        int'(irq_enable && (q.size() <= int'(threshold))));
    chk("mon_overflow", int'(overflow), int'(m_ovf));
    if (q.size() > 0) chk("mon_rd_data", int'(rd_data), int'(q[0]));
  end

  task automatic cyc(input bit wv, input int wd, input bit rr,
                     input bit fl = 1'b0, input bit oc = 1'b0);
    wr_valid = wv;
    wr_data = 8'(wd);
    rd_ready = rr;
    flush = fl;
    overflow_clear = oc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    irq_enable = 1'b1;
    threshold = 5'd0;
    reset = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    reset = 1'b1;
    chk("rst_level", int'(level), 0);
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_irq", int'(irq), 1);

    cyc(1, 'h41, 0);
    cyc(0, 0, 0);
    chk("one_rd_valid", int'(rd_valid), 1);
    chk("one_rd_data", int'(rd_data), 'h41);
    chk("one_level", int'(level), 1);
    cyc(0, 0, 1);
    chk("one_pop_valid", int'(rd_valid), 0);
    chk("one_pop_level", int'(level), 0);

    for (int i = 0; i < 16; i++) cyc(1, i, 0);
    cyc(0, 0, 0);
    chk("full_level", int'(level), 16);
    chk("full_wr_ready", int'(wr_ready), 0);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", int'(rd_data), i);
      cyc(0, 0, 1);
    end
    chk("drain_empty", int'(rd_valid), 0);

    for (int i = 0; i < 20; i++) cyc(1, 'h20 + i, i >= 10);
    cyc(0, 0, 0);
    chk("wrap_level", int'(level), 10);
    chk("wrap_head", int'(rd_data), 'h2a);
    for (int i = 0; i < 6; i++) cyc(1, 'h40 + i, 0);
    chk("refill_full", int'(level), 16);

    cyc(1, 'hee, 1);
    chk("ovf_wr_pop_level", int'(level), 15);
    chk("ovf_set", int'(overflow), OVF_ON);
    cyc(1, 'h50, 0);
    cyc(1, 'h51, 0, 0, 1);
    chk("ovf_set_wins", int'(overflow), OVF_ON);
    cyc(0, 0, 0, 0, 1);
    chk("ovf_cleared", int'(overflow), 0);

    cyc(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 'h60 + i, 0);
    cyc(1, 'h65, 1);
    chk("wrpop_level", int'(level), 5);
    cyc(1, 'h66, 1, 1);
    chk("flush_level", int'(level), 0);
    chk("flush_rd_valid", int'(rd_valid), 0);

    threshold = 5'd2;
    irq_enable = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1, 'h70 + i, 0);
    cyc(0, 0, 0);
    chk("irq_above", int'(irq), 0);
    cyc(0, 0, 1);
    chk("irq_at_thr", int'(irq), 1);
    for (int i = 0; i < 6; i++) cyc(1, 'h80 + i, 0);
    chk("pre_rst_level", int'(level), 8);
    reset = 1'b0;
    cyc(1, 'h99, 1);
    reset = 1'b1;
    chk("mid_rst_level", int'(level), 0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) threshold = TW'($urandom_range(0, 16));
      if ($urandom_range(0, 49) == 0) irq_enable = 1'($urandom);
      reset = ($urandom_range(0, 299) != 0);
      cyc($urandom_range(0, 99) < 60, int'($urandom_range(0, 255)),
          $urandom_range(0, 99) < ((n / 500) % 2 ? 70 : 35),
          $urandom_range(0, 149) == 0,
          $urandom_range(0, 19) == 0);
    end
    reset = 1'b1;
    cyc(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
